// File: rtl/aud_recorder_mc.sv
// Multi-channel I2S capture engine: deserialises left, right or stereo ADC words on BCLK
// and emits one-cycle SRAM write strobes, with start/pause/stop and buffer-full handling.
module aud_recorder_mc #(
    parameter int SAMPLE_W  = 16,
    parameter int ADDR_W    = 20,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_lrc,
    input  logic                i_data,
    input  logic                i_start,
    input  logic                i_pause,
    input  logic                i_stop,
    input  logic [1:0]          i_mode,
    output logic [ADDR_W-1:0]   o_address,
    output logic [SAMPLE_W-1:0] o_data,
    output logic                o_we,
    output logic                o_ch,
    output logic [ADDR_W:0]     o_count,
    output logic                o_full,
    output logic [2:0]          o_state
);

    localparam int                CNT_W     = $clog2(SAMPLE_W);
    localparam logic [CNT_W-1:0]  LSB_IDX   = CNT_W'(SAMPLE_W - 1);
    localparam logic [CNT_W-1:0]  BIT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WORD_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_FULL    = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                lrc_q;
    logic [1:0]          mode_q, mode_d;
    logic                pause_pend_q, pause_pend_d;
    logic                slot_ch_q, slot_ch_d;
    logic                active_q, active_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] shreg_q, shreg_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic                och_q, och_d;
    logic                we_q, we_d;
    logic                full_q, full_d;

    logic                lrc_fall, lrc_edge, pause_now;
    logic [SAMPLE_W-1:0] shifted;

    assign lrc_fall  = lrc_q & ~i_lrc;
    assign lrc_edge  = lrc_q ^ i_lrc;
    assign pause_now = pause_pend_q | i_pause;
    assign shifted   = {shreg_q[SAMPLE_W-2:0], i_data};

    // Mode 3 is reserved and behaves as left-only.
    function automatic logic slot_en(input logic [1:0] mode, input logic ch);
        case (mode)
            2'd1:    return ch;
            2'd2:    return 1'b1;
            default: return ~ch;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case below can infer a latch.
        state_d      = state_q;
        mode_d       = mode_q;
        pause_pend_d = pause_pend_q;
        slot_ch_d    = slot_ch_q;
        active_d     = active_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        ptr_d        = ptr_q;
        count_d      = count_q;
        addr_d       = addr_q;
        data_d       = data_q;
        och_d        = och_q;
        we_d         = 1'b0;
        full_d       = full_q;

        if (i_stop && state_q != ST_IDLE) begin
            state_d      = ST_IDLE;
            active_d     = 1'b0;
            pause_pend_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start && !i_pause && !i_stop) begin
                        ptr_d   = '0;
                        count_d = '0;
                        mode_d  = i_mode;
                        full_d  = 1'b0;
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (i_pause) begin
                        state_d = ST_PAUSED;
                    end else if (lrc_fall) begin
                        // This edge cycle carries the I2S delay bit; shifting starts next cycle.
                        state_d   = ST_CAPTURE;
                        slot_ch_d = 1'b0;
                        bit_cnt_d = '0;
                        active_d  = slot_en(mode_q, 1'b0);
                    end
                end
                ST_CAPTURE: begin
                    pause_pend_d = pause_now;
                    if (lrc_edge) begin
                        // A new slot always discards whatever a short previous slot left behind.
                        slot_ch_d = i_lrc;
                        bit_cnt_d = '0;
                        active_d  = slot_en(mode_q, i_lrc);
                    end else if (active_q) begin
                        shreg_d   = shifted;
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                        if (bit_cnt_q == LSB_IDX) begin
                            active_d = 1'b0;
                            we_d     = 1'b1;
                            data_d   = shifted;
                            addr_d   = ptr_q;
                            och_d    = slot_ch_q;
                            count_d  = count_q + WORD_ONE;
                            if (ptr_q == LAST_ADDR) begin
                                state_d      = ST_FULL;
                                full_d       = 1'b1;
                                pause_pend_d = 1'b0;
                            end else begin
                                ptr_d = ptr_q + PTR_ONE;
                                // Stereo pauses only after the R word so an L/R pair is never split.
                                if (pause_now && (mode_q != 2'd2 || slot_ch_q)) begin
                                    state_d      = ST_PAUSED;
                                    pause_pend_d = 1'b0;
                                end
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!i_pause && i_start) begin
                        mode_d  = i_mode;
                        state_d = ST_ARMED;
                    end
                end
                ST_FULL: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            lrc_q        <= 1'b0;
            mode_q       <= 2'd0;
            pause_pend_q <= 1'b0;
            slot_ch_q    <= 1'b0;
            active_q     <= 1'b0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            ptr_q        <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            och_q        <= 1'b0;
            we_q         <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lrc_q        <= i_lrc;
            mode_q       <= mode_d;
            pause_pend_q <= pause_pend_d;
            slot_ch_q    <= slot_ch_d;
            active_q     <= active_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            ptr_q        <= ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            och_q        <= och_d;
            we_q         <= we_d;
            full_q       <= full_d;
        end
    end

    assign o_address = addr_q;
    assign o_data    = data_q;
    assign o_we      = we_q;
    assign o_ch      = och_q;
    assign o_count   = count_q;
    assign o_full    = full_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_aud_recorder_mc.sv
// Scoreboard bench for aud_recorder_mc: a slot-level recorder model queues the expected SRAM
// writes, and a monitor pops one entry for every o_we pulse of either of two configurations.
module tb_aud_recorder_mc;

    localparam int SW_A = 16, AW_A = 6, MAX_A = 64;
    localparam int SW_B = 24, AW_B = 3, MAX_B = 5;
    localparam int EV_NONE = 0, EV_PAUSE = 1, EV_STOP = 2;
    localparam int S_IDLE = 0, S_ARMED = 1, S_CAP = 2, S_PAUSED = 3, S_FULL = 4;

    logic       i_clk   = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_lrc   = 1'b1;
    logic       i_data  = 1'b0;
    logic [1:0] i_mode  = 2'd0;
    logic [1:0] start_v = '0, pause_v = '0, stop_v = '0;

    logic [AW_A-1:0] a_addr;  logic [SW_A-1:0] a_data;  logic [AW_A:0] a_count;
    logic [AW_B-1:0] b_addr;  logic [SW_B-1:0] b_data;  logic [AW_B:0] b_count;
    logic a_we, a_ch, a_full, b_we, b_ch, b_full;
    logic [2:0] a_state, b_state;

    aud_recorder_mc #(.SAMPLE_W(SW_A), .ADDR_W(AW_A), .MAX_WORDS(MAX_A)) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lrc(i_lrc), .i_data(i_data),
        .i_start(start_v[0]), .i_pause(pause_v[0]), .i_stop(stop_v[0]), .i_mode(i_mode),
        .o_address(a_addr), .o_data(a_data), .o_we(a_we), .o_ch(a_ch),
        .o_count(a_count), .o_full(a_full), .o_state(a_state));

    aud_recorder_mc #(.SAMPLE_W(SW_B), .ADDR_W(AW_B), .MAX_WORDS(MAX_B)) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_lrc(i_lrc), .i_data(i_data),
        .i_start(start_v[1]), .i_pause(pause_v[1]), .i_stop(stop_v[1]), .i_mode(i_mode),
        .o_address(b_addr), .o_data(b_data), .o_we(b_we), .o_ch(b_ch),
        .o_count(b_count), .o_full(b_full), .o_state(b_state));

    always #5 i_clk = ~i_clk;

    typedef struct {
        int addr;
        int data;
        int ch;
        int cnt;
    } exp_t;

    exp_t q0[$], q1[$];
    int   n_cmp = 0, n_err = 0;

    // Recorder model per DUT: o_state value, words written, latched mode, pending pause, full flag.
    int m_st[2], m_cnt[2], m_mode[2];
    bit m_pend[2], m_full[2];

    function automatic int sw(input int t);
        return (t == 0) ? SW_A : SW_B;
    endfunction

    function automatic int maxw(input int t);
        return (t == 0) ? MAX_A : MAX_B;
    endfunction

    function automatic bit en(input int mode, input int ch);
        if (mode == 1) return ch == 1;
        if (mode == 2) return 1'b1;
        return ch == 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input int t, input string tag);
        check({tag, "_state"}, (t == 0) ? 32'(a_state) : 32'(b_state), m_st[t]);
        check({tag, "_count"}, (t == 0) ? 32'(a_count) : 32'(b_count), m_cnt[t]);
        check({tag, "_full"},  (t == 0) ? 32'(a_full)  : 32'(b_full),  32'(m_full[t]));
    endtask

    // One I2S slot as the recorder sees it: the word lands only if capture is running,
    // the slot is enabled, it holds SAMPLE_W bits, and no stop arrives first.
    task automatic model_slot(input int t, input int ch, input logic [23:0] word,
                              input int len, input int ev);
        exp_t e;
        if (m_st[t] == S_ARMED && ch == 0) m_st[t] = S_CAP;
        if (ev == EV_STOP) begin
            if (m_st[t] != S_IDLE) begin
                m_st[t]   = S_IDLE;
                m_pend[t] = 1'b0;
            end
            return;
        end
        if (ev == EV_PAUSE) begin
            if (m_st[t] == S_ARMED) m_st[t] = S_PAUSED;
            else if (m_st[t] == S_CAP) m_pend[t] = 1'b1;
        end
        if (m_st[t] == S_CAP && en(m_mode[t], ch) && len - 1 >= sw(t)) begin
            e.addr = m_cnt[t];
            e.data = int'(word) & ((1 << sw(t)) - 1);
            e.ch   = ch;
            e.cnt  = m_cnt[t] + 1;
            if (t == 0) q0.push_back(e); else q1.push_back(e);
            m_cnt[t]++;
            if (m_cnt[t] == maxw(t)) begin
                m_st[t]   = S_FULL;
                m_full[t] = 1'b1;
                m_pend[t] = 1'b0;
            end else if (m_pend[t] && (m_mode[t] != 2 || ch == 1)) begin
                m_st[t]   = S_PAUSED;
                m_pend[t] = 1'b0;
            end
        end
    endtask

    // Cycle 0 is the lrc edge (delay bit), cycles 1..SAMPLE_W carry the word MSB first.
    task automatic send_slot(input int t, input int ch, input logic [23:0] word,
                             input int len, input int ev, input int evb);
        int s;
        s = sw(t);
        model_slot(t, ch, word, len, ev);
        for (int c = 0; c < len; c++) begin
            @(negedge i_clk);
            i_lrc   = 1'(ch);
            i_data  = (c >= 1 && c <= s) ? word[s-c] : 1'($urandom);
            pause_v = '0;
            stop_v  = '0;
            if (c == evb && ev == EV_PAUSE) pause_v[t] = 1'b1;
            if (c == evb && ev == EV_STOP)  stop_v[t]  = 1'b1;
        end
    endtask

    task automatic send_frame(input int t, input logic [23:0] l, input logic [23:0] r, input int len);
        send_slot(t, 0, l, len, EV_NONE, 0);
        send_slot(t, 1, r, len, EV_NONE, 0);
    endtask

    task automatic settle();
        @(negedge i_clk);
        start_v = '0;
        pause_v = '0;
        stop_v  = '0;
    endtask

    task automatic do_start(input int t, input int mode);
        settle();
        i_mode     = 2'(mode);
        start_v[t] = 1'b1;
        settle();
        if (m_st[t] == S_IDLE) begin
            m_cnt[t]  = 0;
            m_full[t] = 1'b0;
            m_mode[t] = mode;
            m_st[t]   = S_ARMED;
        end else if (m_st[t] == S_PAUSED) begin
            m_mode[t] = mode;
            m_st[t]   = S_ARMED;
        end
    endtask

    task automatic do_pause(input int t);
        settle();
        pause_v[t] = 1'b1;
        settle();
        if (m_st[t] == S_ARMED) m_st[t] = S_PAUSED;
        else if (m_st[t] == S_CAP) m_pend[t] = 1'b1;
    endtask

    task automatic do_stop(input int t);
        settle();
        stop_v[t] = 1'b1;
        settle();
        if (m_st[t] != S_IDLE) begin
            m_st[t]   = S_IDLE;
            m_pend[t] = 1'b0;
        end
    endtask

    function automatic int slot_len_a();
        return $urandom_range(SW_A + 1, SW_A + 8);
    endfunction

    // Scoreboard monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (a_we === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected_write: got write addr=%0d data=0x%0h, expected none", a_addr, a_data);
            end else begin
                e = q0.pop_front();
                check("a_wr_addr", 32'(a_addr), e.addr);
                check("a_wr_data", 32'(a_data), e.data);
                check("a_wr_ch", 32'(a_ch), e.ch);
                check("a_wr_count", 32'(a_count), e.cnt);
            end
        end
        if (b_we === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected_write: got write addr=%0d data=0x%0h, expected none", b_addr, b_data);
            end else begin
                e = q1.pop_front();
                check("b_wr_addr", 32'(b_addr), e.addr);
                check("b_wr_data", 32'(b_data), e.data);
                check("b_wr_ch", 32'(b_ch), e.ch);
                check("b_wr_count", 32'(b_count), e.cnt);
            end
        end
    end

    initial begin
        for (int t = 0; t < 2; t++) begin
            m_st[t] = S_IDLE; m_cnt[t] = 0; m_mode[t] = 0; m_pend[t] = 1'b0; m_full[t] = 1'b0;
        end
        repeat (3) @(negedge i_clk);
        check("rst_a_state", 32'(a_state), S_IDLE);
        check("rst_a_count", 32'(a_count), 0);
        check("rst_a_we", 32'(a_we), 0);
        check("rst_a_addr", 32'(a_addr), 0);
        check("rst_a_data", 32'(a_data), 0);
        check("rst_a_full", 32'(a_full), 0);
        check("rst_b_state", 32'(b_state), S_IDLE);
        i_rst_n = 1'b1;
        settle();

        // Mono left: only the left words are recorded.
        do_start(0, 0);
        for (int f = 0; f < 3; f++) send_frame(0, 24'hA5C3, 24'h1234, slot_len_a());
        settle();
        check("mono_count", 32'(a_count), 3);
        check("mono_addr", 32'(a_addr), 2);
        check("mono_data", 32'(a_data), 32'hA5C3);
        check("mono_ch", 32'(a_ch), 0);
        check("mono_state", 32'(a_state), S_CAP);

        // Asynchronous reset mid-word wipes everything.
        for (int c = 0; c < 9; c++) begin
            @(negedge i_clk);
            i_lrc  = 1'b0;
            i_data = 1'($urandom);
        end
        #2 i_rst_n = 1'b0;
        #1;
        check("midrst_state", 32'(a_state), S_IDLE);
        check("midrst_count", 32'(a_count), 0);
        check("midrst_addr", 32'(a_addr), 0);
        check("midrst_data", 32'(a_data), 0);
        m_st[0] = S_IDLE; m_cnt[0] = 0; m_full[0] = 1'b0; m_pend[0] = 1'b0;
        @(negedge i_clk);
        i_lrc   = 1'b1;
        i_rst_n = 1'b1;

        // Stereo with a pause requested during the L bits of frame 2.
        do_start(0, 2);
        send_frame(0, 24'h0001, 24'h8000, slot_len_a());
        send_slot(0, 0, 24'h0001, slot_len_a(), EV_PAUSE, 5);
        send_slot(0, 1, 24'h8000, slot_len_a(), EV_NONE, 0);
        settle();
        check("pause_state", 32'(a_state), S_PAUSED);
        check("pause_count", 32'(a_count), 4);
        send_frame(0, 24'($urandom), 24'($urandom), slot_len_a());
        do_start(0, 2);
        for (int f = 0; f < 2; f++) send_frame(0, 24'($urandom), 24'($urandom), slot_len_a());
        settle();
        check("resume_count", 32'(a_count), 8);
        check_status(0, "resume");

        // Stop mid-word, stop on the LSB, short slot, pause on the LSB of the last word.
        do_stop(0);
        do_start(0, 0);
        send_frame(0, 24'($urandom), 24'($urandom), slot_len_a());
        send_slot(0, 0, 24'($urandom), slot_len_a(), EV_STOP, 8);
        send_slot(0, 1, 24'($urandom), slot_len_a(), EV_NONE, 0);
        settle();
        check("stop_state", 32'(a_state), S_IDLE);
        check("stop_count", 32'(a_count), 1);
        do_start(0, 0);
        send_slot(0, 0, 24'($urandom), SW_A + 1, EV_STOP, SW_A);
        settle();
        check("stop_lsb_count", 32'(a_count), 0);
        check_status(0, "stop_lsb");
        send_slot(0, 1, 24'($urandom), slot_len_a(), EV_NONE, 0);
        do_start(0, 0);
        send_slot(0, 0, 24'($urandom), 11, EV_NONE, 0);
        send_slot(0, 1, 24'($urandom), slot_len_a(), EV_NONE, 0);
        send_frame(0, 24'($urandom), 24'($urandom), slot_len_a());
        settle();
        check("short_count", 32'(a_count), 1);
        do_stop(0);
        do_start(0, 0);
        send_slot(0, 0, 24'($urandom), SW_A + 1, EV_PAUSE, SW_A);
        send_slot(0, 1, 24'($urandom), slot_len_a(), EV_NONE, 0);
        settle();
        check("pause_lsb_state", 32'(a_state), S_PAUSED);
        check("pause_lsb_count", 32'(a_count), 1);

        // Randomised sessions: mode, slot lengths, short slots, pauses, stops, resumes.
        for (int it = 0; it < 10; it++) begin
            do_stop(0);
            do_start(0, $urandom_range(0, 3));
            for (int f = 0; f < 6; f++) begin
                if ($urandom_range(0, 5) == 0) do_start(0, $urandom_range(0, 3));
                for (int ch = 0; ch < 2; ch++) begin
                    int len, ev, evb, r;
                    len = ($urandom_range(0, 9) == 0) ? $urandom_range(4, SW_A) : slot_len_a();
                    r   = $urandom_range(0, 19);
                    ev  = (r == 0) ? EV_STOP : (r < 3) ? EV_PAUSE : EV_NONE;
                    evb = $urandom_range(1, (len - 1 < SW_A) ? len - 1 : SW_A);
                    send_slot(0, ch, 24'($urandom), len, ev, evb);
                end
            end
            settle();
            check_status(0, "rand");
        end
        do_stop(0);

        // 24-bit words in 32-bit slots, five-word buffer: mono fills it, start/pause ignored.
        do_start(1, 0);
        for (int f = 0; f < 7; f++) send_frame(1, 24'hABCDEF, 24'($urandom), 32);
        settle();
        check("full_state", 32'(b_state), S_FULL);
        check("full_flag", 32'(b_full), 1);
        check("full_count", 32'(b_count), MAX_B);
        check("full_addr", 32'(b_addr), MAX_B - 1);
        check("full_data", 32'(b_data), 32'hABCDEF);
        do_start(1, 0);
        do_pause(1);
        check_status(1, "full_ignore");
        do_stop(1);
        check("full_stop_state", 32'(b_state), S_IDLE);
        check("full_stop_flag", 32'(b_full), 1);

        // Stereo into an odd-sized buffer ends on a lone L word.
        do_start(1, 2);
        check("restart_full", 32'(b_full), 0);
        for (int f = 0; f < 3; f++) send_frame(1, 24'($urandom), 24'($urandom), 32);
        settle();
        check("odd_last_ch", 32'(b_ch), 0);
        check_status(1, "odd_full");
        do_stop(1);

        repeat (3) settle();
        check("a_writes_missing", q0.size(), 0);
        check("b_writes_missing", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
